// File: rtl/ahblite_rtc_slave.sv
// AHB-Lite responder for the desk clock: wall-clock time with a programmable prescaler,
// alarm compare, sticky W1C status flags and a registered interrupt.
module ahblite_rtc_slave #(
    parameter logic [31:0] PRESCALE_RST = 32'd49_999_999,
    parameter int unsigned HOUR_MAX     = 23
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        irq,
    output logic        sec_pulse
);

    localparam logic [4:0] HOUR_LAST = HOUR_MAX[4:0];

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_TIME     = 3'd2;
    localparam logic [2:0] OFF_ALARM    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    typedef enum logic [1:0] {
        RESP_OKAY,
        RESP_ERR1,
        RESP_ERR2
    } resp_t;

    resp_t       r_respState;
    resp_t       w_respNext;

    logic        r_dValid;
    logic        r_dWrite;
    logic [2:0]  r_dOffset;

    logic [2:0]  r_ctrl;
    logic [31:0] r_prescale;
    logic [31:0] r_count;
    logic [5:0]  r_sec;
    logic [5:0]  r_min;
    logic [4:0]  r_hour;
    logic        r_almEn;
    logic [5:0]  r_almSec;
    logic [5:0]  r_almMin;
    logic [4:0]  r_almHour;
    logic        r_secFlag;
    logic        r_almFlag;
    logic        r_irq;

    logic        w_accept;
    logic        w_err;
    logic        w_wr;
    logic        w_wrCtrl;
    logic        w_wrPre;
    logic        w_wrTime;
    logic        w_wrAlarm;
    logic        w_wrStatus;
    logic        w_tick;
    logic        w_secWrap;
    logic        w_minWrap;
    logic [5:0]  w_secNext;
    logic [5:0]  w_minNext;
    logic [4:0]  w_hourNext;
    logic        w_almHit;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = ^{HTRANS[0], HADDR[31:5], HADDR[1:0]};

    assign w_accept = HSEL & HTRANS[1] & HREADY;
    assign w_err    = (HADDR[4:2] > OFF_STATUS) | (HSIZE != 3'b010);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_respState <= RESP_OKAY;
        end else begin
            r_respState <= w_respNext;
        end
    end

    // ERROR needs two cycles: the first stalls the bus so the master can cancel its next transfer.
    always_comb begin
        w_respNext = r_respState;
        case (r_respState)
            RESP_OKAY: if (w_accept & w_err) w_respNext = RESP_ERR1;
            RESP_ERR1: w_respNext = RESP_ERR2;
            RESP_ERR2: w_respNext = (w_accept & w_err) ? RESP_ERR1 : RESP_OKAY;
            default:   w_respNext = RESP_OKAY;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dValid  <= 1'b0;
            r_dWrite  <= 1'b0;
            r_dOffset <= 3'd0;
        end else begin
            r_dValid  <= w_accept & ~w_err;
            r_dWrite  <= HWRITE;
            r_dOffset <= HADDR[4:2];
        end
    end

    assign w_wr       = r_dValid & r_dWrite;
    assign w_wrCtrl   = w_wr & (r_dOffset == OFF_CTRL);
    assign w_wrPre    = w_wr & (r_dOffset == OFF_PRESCALE);
    assign w_wrTime   = w_wr & (r_dOffset == OFF_TIME);
    assign w_wrAlarm  = w_wr & (r_dOffset == OFF_ALARM);
    assign w_wrStatus = w_wr & (r_dOffset == OFF_STATUS);

    assign w_tick = r_ctrl[0] & (r_count == r_prescale);

    // Using >= rather than == lets out-of-range loaded values wrap on their next increment.
    assign w_secWrap  = (r_sec >= 6'd59);
    assign w_minWrap  = w_secWrap & (r_min >= 6'd59);
    assign w_secNext  = w_secWrap ? 6'd0 : r_sec + 6'd1;
    assign w_minNext  = w_secWrap ? ((r_min >= 6'd59) ? 6'd0 : r_min + 6'd1) : r_min;
    assign w_hourNext = w_minWrap ? ((r_hour >= HOUR_LAST) ? 5'd0 : r_hour + 5'd1) : r_hour;

    assign w_almHit = w_tick & ~w_wrTime & r_almEn &
                      ({w_hourNext, w_minNext, w_secNext} == {r_almHour, r_almMin, r_almSec});

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ctrl     <= 3'd0;
            r_prescale <= PRESCALE_RST;
            r_count    <= 32'd0;
            r_sec      <= 6'd0;
            r_min      <= 6'd0;
            r_hour     <= 5'd0;
            r_almEn    <= 1'b0;
            r_almSec   <= 6'd0;
            r_almMin   <= 6'd0;
            r_almHour  <= 5'd0;
            r_secFlag  <= 1'b0;
            r_almFlag  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wrCtrl) r_ctrl <= HWDATA[2:0];
            if (w_wrPre)  r_prescale <= HWDATA;
            if (w_wrAlarm) begin
                r_almEn   <= HWDATA[31];
                r_almHour <= HWDATA[20:16];
                r_almMin  <= HWDATA[13:8];
                r_almSec  <= HWDATA[5:0];
            end

            if (w_wrPre | w_wrTime | w_tick) begin
                r_count <= 32'd0;
            end else if (r_ctrl[0]) begin
                r_count <= r_count + 32'd1;
            end

            // A software load beats a coincident tick; the tick's increment is dropped.
            if (w_wrTime) begin
                r_hour <= HWDATA[20:16];
                r_min  <= HWDATA[13:8];
                r_sec  <= HWDATA[5:0];
            end else if (w_tick) begin
                r_hour <= w_hourNext;
                r_min  <= w_minNext;
                r_sec  <= w_secNext;
            end

            if (w_tick) begin
                r_secFlag <= 1'b1;
            end else if (w_wrStatus & HWDATA[0]) begin
                r_secFlag <= 1'b0;
            end
            if (w_almHit) begin
                r_almFlag <= 1'b1;
            end else if (w_wrStatus & HWDATA[1]) begin
                r_almFlag <= 1'b0;
            end

            r_irq <= (r_ctrl[1] & r_almFlag) | (r_ctrl[2] & r_secFlag);
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (r_dValid & ~r_dWrite) begin
            case (r_dOffset)
                OFF_CTRL:     w_rdata = {29'd0, r_ctrl};
                OFF_PRESCALE: w_rdata = r_prescale;
                OFF_TIME:     w_rdata = {11'd0, r_hour, 2'd0, r_min, 2'd0, r_sec};
                OFF_ALARM:    w_rdata = {r_almEn, 10'd0, r_almHour, 2'd0, r_almMin, 2'd0, r_almSec};
                OFF_STATUS:   w_rdata = {30'd0, r_almFlag, r_secFlag};
                default:      w_rdata = 32'd0;
            endcase
        end
    end

    assign HRDATA    = w_rdata;
    assign HREADYOUT = (r_respState != RESP_ERR1);
    assign HRESP     = (r_respState != RESP_OKAY);
    assign irq       = r_irq;
    assign sec_pulse = w_tick;

endmodule

// File: tb/tb_ahblite_rtc_slave.sv
// Self-checking bench for ahblite_rtc_slave: a behavioural register/time model is compared
// against the DUT every cycle, plus directed literal checks and a randomized bus phase.
module tb_ahblite_rtc_slave;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    wire         HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        irq;
    logic        sec_pulse;

    int assertCount = 0;
    int failCount   = 0;

    always #5 HCLK = ~HCLK;

    // Single-slave interconnect: the bus ready is this slave's ready.
    assign HREADY = HREADYOUT;

    ahblite_rtc_slave dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .irq       (irq),
        .sec_pulse (sec_pulse)
    );

    // Reference model state: time kept as plain integers, registers as words.
    logic [2:0]  mCtrl;
    logic [31:0] mPre;
    logic [31:0] mCnt;
    logic [31:0] mAlarm;
    int          mH, mM, mS;
    logic        mSecF, mAlmF, mIrq;
    logic        mPend, mPendWr;
    logic [2:0]  mPendOff;
    int          mErr;
    bit          modelLive = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] regValue(input logic [2:0] off);
        case (off)
            3'd0:    return {29'd0, mCtrl};
            3'd1:    return mPre;
            3'd2:    return {11'd0, 5'(mH), 2'd0, 6'(mM), 2'd0, 6'(mS)};
            3'd3:    return mAlarm;
            3'd4:    return {30'd0, mAlmF, mSecF};
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelStep();
        logic        tick, hit, acc, err;
        logic        wrC, wrP, wrT, wrA, wrS;
        logic [31:0] wd;
        int          ns, nm, nh;
        if (HRESET) begin
            mCtrl = 3'd0; mPre = 32'd49_999_999; mCnt = 32'd0; mAlarm = 32'd0;
            mH = 0; mM = 0; mS = 0;
            mSecF = 1'b0; mAlmF = 1'b0; mIrq = 1'b0;
            mPend = 1'b0; mPendWr = 1'b0; mPendOff = 3'd0; mErr = 0;
            modelLive = 1'b1;
            return;
        end
        wd  = HWDATA;
        wrC = mPend && mPendWr && (mPendOff == 3'd0);
        wrP = mPend && mPendWr && (mPendOff == 3'd1);
        wrT = mPend && mPendWr && (mPendOff == 3'd2);
        wrA = mPend && mPendWr && (mPendOff == 3'd3);
        wrS = mPend && mPendWr && (mPendOff == 3'd4);
        tick = mCtrl[0] && (mCnt == mPre);
        ns = mS; nm = mM; nh = mH;
        if (tick) begin
            if (mS >= 59) begin
                ns = 0;
                if (mM >= 59) begin
                    nm = 0;
                    nh = (mH >= 23) ? 0 : mH + 1;
                end else begin
                    nm = mM + 1;
                end
            end else begin
                ns = mS + 1;
            end
        end
        hit = tick && !wrT && mAlarm[31] && (ns == int'(mAlarm[5:0])) &&
              (nm == int'(mAlarm[13:8])) && (nh == int'(mAlarm[20:16]));
        mIrq = (mCtrl[1] && mAlmF) || (mCtrl[2] && mSecF);
        if (wrS && wd[0]) mSecF = 1'b0;
        if (tick)         mSecF = 1'b1;
        if (wrS && wd[1]) mAlmF = 1'b0;
        if (hit)          mAlmF = 1'b1;
        if (wrT) begin
            mH = int'(wd[20:16]); mM = int'(wd[13:8]); mS = int'(wd[5:0]);
        end else begin
            mH = nh; mM = nm; mS = ns;
        end
        if (wrP || wrT || tick) mCnt = 32'd0;
        else if (mCtrl[0])      mCnt = mCnt + 32'd1;
        if (wrC) mCtrl = wd[2:0];
        if (wrP) mPre = wd;
        if (wrA) mAlarm = wd & 32'h801F_3F3F;
        acc = HSEL && HTRANS[1] && (mErr != 1);
        err = (HADDR[4:2] > 3'd4) || (HSIZE != 3'b010);
        mPend    = acc && !err;
        mPendWr  = HWRITE;
        mPendOff = HADDR[4:2];
        mErr     = (mErr == 1) ? 2 : ((acc && err) ? 1 : 0);
    endtask

    always @(posedge HCLK) modelStep();

    always @(negedge HCLK) begin
        if (modelLive && !HRESET) begin
            checkOutput("HREADYOUT", 32'(HREADYOUT), (mErr == 1) ? 32'd0 : 32'd1);
            checkOutput("HRESP", 32'(HRESP), (mErr != 0) ? 32'd1 : 32'd0);
            checkOutput("HRDATA", HRDATA, (mPend && !mPendWr) ? regValue(mPendOff) : 32'd0);
            checkOutput("irq", 32'(irq), 32'(mIrq));
            checkOutput("sec_pulse", 32'(sec_pulse), 32'(mCtrl[0] && (mCnt == mPre)));
        end
    end

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        @(posedge HCLK);
        #1;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        HWDATA = wdata;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 2'b00, 1'b0, $urandom(), 3'b010, $urandom());
    endtask

    task automatic writeReg(input logic [2:0] off, input logic [31:0] data);
        applyStimulus(1'b1, 2'b10, 1'b1, {27'd0, off, 2'd0}, 3'b010, $urandom());
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 3'b010, data);
    endtask

    task automatic readReg(input logic [2:0] off, output logic [31:0] data);
        applyStimulus(1'b1, 2'b10, 1'b0, {27'd0, off, 2'd0}, 3'b010, $urandom());
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 3'b010, $urandom());
        @(negedge HCLK);
        data = HRDATA;
    endtask

    function automatic logic [31:0] randomData(input logic [2:0] off);
        case (off)
            3'd0:    return 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
            3'd1:    return 32'($urandom_range(0, 5));
            3'd2:    return ($urandom() & 32'hFFE0_C0C0) |
                            {11'd0, 5'($urandom_range(0, 31)), 2'd0, 6'($urandom_range(0, 63)), 2'd0, 6'($urandom_range(0, 63))};
            3'd3:    return {1'b1, 10'd0, 5'($urandom_range(0, 1)), 2'd0, 6'($urandom_range(0, 1)), 2'd0, 6'($urandom_range(0, 63))};
            3'd4:    return 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    task automatic randomPhase(input int cycles);
        logic        s, w;
        logic [1:0]  t;
        logic [2:0]  off, sz;
        logic [31:0] a, pendData;
        pendData = $urandom();
        for (int i = 0; i < cycles; i++) begin
            s   = ($urandom_range(0, 9) != 0);
            t   = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            off = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
            a   = $urandom();
            a[4:2] = off;
            applyStimulus(s, t, w, a, sz, pendData);
            pendData = randomData(off);
        end
    endtask

    initial begin
        logic [31:0] rd;
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'd0;
        HSIZE  = 3'b010;
        HWDATA = 32'd0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("reset HREADYOUT", 32'(HREADYOUT), 32'd1);
        checkOutput("reset HRESP", 32'(HRESP), 32'd0);
        checkOutput("reset irq", 32'(irq), 32'd0);
        checkOutput("reset HRDATA", HRDATA, 32'd0);

        readReg(3'd1, rd);
        checkOutput("PRESCALE reset value", rd, 32'h02FA_F07F);
        readReg(3'd2, rd);
        checkOutput("TIME reset value", rd, 32'd0);

        $display("[TB] prescaler period 4");
        writeReg(3'd1, 32'd3);
        writeReg(3'd0, 32'd1);
        idleCycles(7);
        readReg(3'd2, rd);
        checkOutput("TIME after 8 cycles", rd, 32'h0000_0002);

        $display("[TB] day wrap");
        writeReg(3'd0, 32'd0);
        writeReg(3'd2, 32'h0017_3B3B);
        writeReg(3'd1, 32'd0);
        writeReg(3'd0, 32'd1);
        readReg(3'd2, rd);
        checkOutput("TIME after 23:59:59 tick", rd, 32'd0);
        writeReg(3'd0, 32'd0);

        $display("[TB] alarm and irq");
        writeReg(3'd3, 32'h8000_0005);
        writeReg(3'd2, 32'd4);
        writeReg(3'd0, 32'd3);
        readReg(3'd4, rd);
        checkOutput("STATUS.ALM at sec 5", rd & 32'd2, 32'd2);
        @(negedge HCLK);
        checkOutput("irq after alarm", 32'(irq), 32'd1);
        writeReg(3'd4, 32'd2);
        idleCycles(2);
        @(negedge HCLK);
        checkOutput("irq after ALM clear", 32'(irq), 32'd0);
        writeReg(3'd0, 32'd0);

        $display("[TB] error responses");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0018, 3'b010, $urandom());
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 3'b010, $urandom());
        @(negedge HCLK);
        checkOutput("bad offset err1 ready/resp", {30'd0, HREADYOUT, HRESP}, 32'b01);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 3'b010, $urandom());
        @(negedge HCLK);
        checkOutput("bad offset err2 ready/resp", {30'd0, HREADYOUT, HRESP}, 32'b11);
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0000_0000, 3'b000, $urandom());
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0000_0000, 3'b010, 32'd7);
        @(negedge HCLK);
        checkOutput("byte write err1 ready/resp", {30'd0, HREADYOUT, HRESP}, 32'b01);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 3'b010, 32'd7);
        @(negedge HCLK);
        checkOutput("byte write err2 ready/resp", {30'd0, HREADYOUT, HRESP}, 32'b11);
        readReg(3'd0, rd);
        checkOutput("CTRL unchanged after errors", rd, 32'd0);

        $display("[TB] back-to-back write/read");
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0000_0000, 3'b010, $urandom());
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0000, 3'b010, 32'h0000_0006);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 3'b010, $urandom());
        @(negedge HCLK);
        checkOutput("CTRL read after write", HRDATA, 32'h0000_0006);

        $display("[TB] W1C colliding with tick");
        writeReg(3'd0, 32'd0);
        writeReg(3'd4, 32'd3);
        writeReg(3'd1, 32'd3);
        writeReg(3'd0, 32'd1);
        idleCycles(2);
        writeReg(3'd4, 32'd1);
        readReg(3'd4, rd);
        checkOutput("SEC survives W1C in tick cycle", rd & 32'd1, 32'd1);

        $display("[TB] reset during write data phase");
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0000_0000, 3'b010, $urandom());
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 32'd7;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        readReg(3'd0, rd);
        checkOutput("CTRL after mid-transfer reset", rd, 32'd0);

        $display("[TB] randomized traffic");
        writeReg(3'd1, 32'd1);
        writeReg(3'd0, 32'd7);
        randomPhase(600);
        idleCycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
